// File: rtl/queue_bank_pkg.sv
// queue_bank_pkg
// Shared defaults and derived widths for the queue bank and anything that
// talks to it (the weighted round-robin arbiter and its bench use these too).
//   DEF_QUEUE_QUANTITY : number of queues (power of two, at least 2)
//   DEF_DATA_BITS      : word width
//   DEF_BUF_WIDTH      : log2 of per-queue depth
//   DEF_SEL_BITS       : width of the arbiter selector
//   DEF_CNT_BITS       : width of a per-queue occupancy count (0..depth)
`ifndef QUEUE_BANK_PKG_SV
`define QUEUE_BANK_PKG_SV

package queue_bank_pkg;

   localparam int DEF_QUEUE_QUANTITY = 4;
   localparam int DEF_DATA_BITS      = 8;
   localparam int DEF_BUF_WIDTH      = 3;
   localparam int DEF_SEL_BITS       = $clog2(DEF_QUEUE_QUANTITY);
   localparam int DEF_CNT_BITS       = DEF_BUF_WIDTH + 1;

endpackage

`endif

// File: rtl/queue_bank_fifo.sv
// queue_fifo
// One FIFO of the bank: storage, read/write pointers and an occupancy count.
// Push and pop arrive already qualified by the top, so this block never has
// to decide whether an operation is legal.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   push_i   : write data_i this edge
//   pop_i    : advance the read pointer this edge
//   data_i   : word to write
//   data_o   : word at the head of the queue
//   empty_o  : count is zero
//   full_o   : count equals depth
module queue_fifo
   import queue_bank_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int BUF_WIDTH = DEF_BUF_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 empty_o,
   output logic                 full_o
);

   localparam int DEPTH = 1 << BUF_WIDTH;
   localparam logic [BUF_WIDTH:0] FULL_COUNT = (BUF_WIDTH + 1)'(DEPTH);

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [BUF_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [BUF_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [BUF_WIDTH:0]   count_q, count_d;

   // Storage is deliberately left out of reset; the count alone decides
   // which entries are live.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   // Pointers wrap naturally at the power-of-two depth. The count only moves
   // when exactly one of push/pop happens.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push_i) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop_i) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      if (push_i && !pop_i) begin
         count_d = count_q + 1'b1;
      end else if (pop_i && !push_i) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   assign data_o  = mem_q[rdPtr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_COUNT);

endmodule

// File: rtl/queue_bank.sv
// queue_bank
// Bank of independent FIFOs feeding the weighted round-robin arbiter. The
// arbiter sees per-queue empty flags and answers with a selector; the chosen
// queue is popped onto a registered output port at one word per cycle.
// Optional feature macro: QUEUE_BANK_ERR_EN adds sticky overflow/underflow
// flags per queue.
// Ports:
//   clk_i           : clock, rising edge
//   rst_ni          : asynchronous active-low reset
//   enb_i           : global enable, 0 freezes every queue
//   push_i          : per-queue write strobe
//   data_in_i       : queue i word at [i*DATA_BITS +: DATA_BITS]
//   selector_i      : queue to pop
//   selector_enb_i  : pop request for selector_i
//   buf_empty_o     : per-queue empty flag
//   buf_full_o      : per-queue full flag
//   data_out_o      : popped word, registered
//   valid_out_o     : data_out_o holds a word popped on the previous edge
//   err_overflow_o  : (QUEUE_BANK_ERR_EN) sticky, push dropped on full queue
//   err_underflow_o : (QUEUE_BANK_ERR_EN) sticky, pop requested on empty queue
module queue_bank
   import queue_bank_pkg::*;
#(
   parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
   parameter int DATA_BITS      = DEF_DATA_BITS,
   parameter int BUF_WIDTH      = DEF_BUF_WIDTH,
   parameter int SEL_BITS       = $clog2(QUEUE_QUANTITY)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                enb_i,
   input  logic [QUEUE_QUANTITY-1:0]           push_i,
   input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in_i,
   input  logic [SEL_BITS-1:0]                 selector_i,
   input  logic                                selector_enb_i,
   output logic [QUEUE_QUANTITY-1:0]           buf_empty_o,
   output logic [QUEUE_QUANTITY-1:0]           buf_full_o,
   output logic [DATA_BITS-1:0]                data_out_o,
   output logic                                valid_out_o
`ifdef QUEUE_BANK_ERR_EN
   ,
   output logic [QUEUE_QUANTITY-1:0]           err_overflow_o,
   output logic [QUEUE_QUANTITY-1:0]           err_underflow_o
`endif
);

   logic [DATA_BITS-1:0]      headData [QUEUE_QUANTITY];
   logic [QUEUE_QUANTITY-1:0] pushOk;
   logic [QUEUE_QUANTITY-1:0] popOk;
   logic                      popAccept;
   logic [DATA_BITS-1:0]      data_q, data_d;
   logic                      valid_q, valid_d;

   // A pop is taken only when the selected queue holds a registered word, so
   // a word pushed this edge cannot be popped until the next one. A push to
   // a full queue still goes through when the same queue is popped, because
   // the slot being read is freed on that edge.
   always_comb begin
      popAccept = enb_i && selector_enb_i && !buf_empty_o[selector_i];
      popOk     = '0;
      pushOk    = '0;
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
         popOk[i]  = popAccept && (selector_i == SEL_BITS'(i));
         pushOk[i] = enb_i && push_i[i] && (!buf_full_o[i] || popOk[i]);
      end
   end

   // One FIFO per queue; each receives its already-qualified strobes.
   for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_queue
      queue_fifo #(
         .DATA_BITS (DATA_BITS),
         .BUF_WIDTH (BUF_WIDTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .push_i  (pushOk[g]),
         .pop_i   (popOk[g]),
         .data_i  (data_in_i[g*DATA_BITS +: DATA_BITS]),
         .data_o  (headData[g]),
         .empty_o (buf_empty_o[g]),
         .full_o  (buf_full_o[g])
      );
   end

   // The output word holds its last value whenever nothing is popped; only
   // the valid bit drops.
   always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (popAccept) begin
         data_d  = headData[selector_i];
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_out_o  = data_q;
   assign valid_out_o = valid_q;

`ifdef QUEUE_BANK_ERR_EN
   logic [QUEUE_QUANTITY-1:0] errOv_q, errOv_d;
   logic [QUEUE_QUANTITY-1:0] errUn_q, errUn_d;

   // Sticky error bits: a dropped push marks its own queue, a pop on an
   // empty queue marks the selected queue. Only reset clears them, and with
   // enb low nothing is attempted so nothing can be flagged.
   always_comb begin
      errOv_d = errOv_q;
      errUn_d = errUn_q;
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
         if (enb_i && push_i[i] && !pushOk[i]) begin
            errOv_d[i] = 1'b1;
         end
         if (enb_i && selector_enb_i && buf_empty_o[i] &&
             (selector_i == SEL_BITS'(i))) begin
            errUn_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         errOv_q <= '0;
         errUn_q <= '0;
      end else begin
         errOv_q <= errOv_d;
         errUn_q <= errUn_d;
      end
   end

   assign err_overflow_o  = errOv_q;
   assign err_underflow_o = errUn_q;
`endif

endmodule

// File: tb/tb_queue_bank.sv
// tb_queue_bank
// Scoreboard bench for queue_bank: a per-queue reference model decides which
// pushes and pops are accepted, popped words are queued as expected output
// and compared when the registered output appears.
module tb_queue_bank;
   import queue_bank_pkg::*;

   localparam int QN    = DEF_QUEUE_QUANTITY;
   localparam int DW    = DEF_DATA_BITS;
   localparam int SW    = DEF_SEL_BITS;
   localparam int DEPTH = 1 << DEF_BUF_WIDTH;

   logic              clk = 1'b0;
   logic              rstN;
   logic              enb;
   logic [QN-1:0]     push;
   logic [QN*DW-1:0]  dataIn;
   logic [SW-1:0]     selector;
   logic              selEnb;
   logic [QN-1:0]     bufEmpty;
   logic [QN-1:0]     bufFull;
   logic [DW-1:0]     dataOut;
   logic              validOut;
`ifdef QUEUE_BANK_ERR_EN
   logic [QN-1:0]     errOv;
   logic [QN-1:0]     errUn;
`endif

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model [QN][$];
   logic [DW-1:0] scoreQ [$];
   logic          expValid;
   logic [DW-1:0] expData;
   logic [QN-1:0] expOv;
   logic [QN-1:0] expUn;

   always #5 clk = ~clk;

   queue_bank dut (
      .clk_i           (clk),
      .rst_ni          (rstN),
      .enb_i           (enb),
      .push_i          (push),
      .data_in_i       (dataIn),
      .selector_i      (selector),
      .selector_enb_i  (selEnb),
      .buf_empty_o     (bufEmpty),
      .buf_full_o      (bufFull),
      .data_out_o      (dataOut),
      .valid_out_o     (validOut)
`ifdef QUEUE_BANK_ERR_EN
      ,
      .err_overflow_o  (errOv),
      .err_underflow_o (errUn)
`endif
   );

   function automatic logic [QN-1:0] modelEmpty();
      logic [QN-1:0] r;
      for (int i = 0; i < QN; i++) r[i] = (model[i].size() == 0);
      return r;
   endfunction

   function automatic logic [QN-1:0] modelFull();
      logic [QN-1:0] r;
      for (int i = 0; i < QN; i++) r[i] = (model[i].size() == DEPTH);
      return r;
   endfunction

   function automatic logic [QN*DW-1:0] slot(input int q, input logic [DW-1:0] w);
      logic [QN*DW-1:0] v;
      v = '0;
      v[q*DW +: DW] = w;
      return v;
   endfunction

   // Drive one cycle of stimulus, update the reference model with what the
   // bank should accept, and return #1 after the active edge.
   task automatic tick(input logic e, input logic [QN-1:0] p,
                       input logic [QN*DW-1:0] d, input logic [SW-1:0] s,
                       input logic se);
      logic          popAcc;
      logic [QN-1:0] pushAcc;
      logic [DW-1:0] w;
      @(negedge clk);
      enb = e; push = p; dataIn = d; selector = s; selEnb = se;
      popAcc  = e && se && (model[s].size() != 0);
      pushAcc = '0;
      for (int i = 0; i < QN; i++) begin
         if (e && p[i]) begin
            if (model[i].size() < DEPTH || (popAcc && s == SW'(i))) pushAcc[i] = 1'b1;
            else expOv[i] = 1'b1;
         end
      end
      if (e && se && !popAcc) expUn[s] = 1'b1;
      if (popAcc) begin
         w = model[s].pop_front();
         scoreQ.push_back(w);
         expValid = 1'b1;
         expData  = w;
      end else begin
         expValid = 1'b0;
      end
      for (int i = 0; i < QN; i++) begin
         if (pushAcc[i]) model[i].push_back(d[i*DW +: DW]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick(1'b1, '0, '0, '0, 1'b0);
   endtask

   task automatic clearModel();
      for (int i = 0; i < QN; i++) model[i].delete();
      scoreQ.delete();
      expValid = 1'b0;
      expData  = '0;
      expOv    = '0;
      expUn    = '0;
   endtask

   task automatic test_reset();
      rstN = 1'b0; enb = 1'b0; push = '0; dataIn = '0; selector = '0; selEnb = 1'b0;
      clearModel();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bufEmpty !== 4'b1111) begin bad++; $display("[TB] FAIL reset_empty got=%b want=%b", bufEmpty, 4'b1111); end
      total++;
      if (bufFull !== 4'b0000) begin bad++; $display("[TB] FAIL reset_full got=%b want=%b", bufFull, 4'b0000); end
      total++;
      if (validOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", validOut); end
      total++;
      if (dataOut !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", dataOut); end
`ifdef QUEUE_BANK_ERR_EN
      total++;
      if (errOv !== '0 || errUn !== '0) begin bad++; $display("[TB] FAIL reset_err got=%b/%b want=0/0", errOv, errUn); end
`endif
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic test_basic_pop();
      logic [DW-1:0] e;
      tick(1'b1, 4'b0100, slot(2, 8'hA1), 2'd0, 1'b0);
      tick(1'b1, 4'b0100, slot(2, 8'hA2), 2'd0, 1'b0);
      total++;
      if (bufEmpty[2] !== 1'b0) begin bad++; $display("[TB] FAIL basic_nonempty got=%b want=0", bufEmpty[2]); end
      for (int k = 0; k < 2; k++) begin
         tick(1'b1, '0, '0, 2'd2, 1'b1);
         total++;
         if (validOut !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%b want=1", validOut); end
         e = scoreQ.pop_front();
         total++;
         if (dataOut !== e) begin bad++; $display("[TB] FAIL basic_data got=%h want=%h", dataOut, e); end
      end
      idle();
      total++;
      if (validOut !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_drop got=%b want=0", validOut); end
      total++;
      if (bufEmpty !== modelEmpty()) begin bad++; $display("[TB] FAIL basic_empty got=%b want=%b", bufEmpty, modelEmpty()); end
   endtask

   task automatic test_fill_wrap();
      logic [DW-1:0] e;
      // Move queue 0 pointers off zero so the fill crosses the wrap point.
      for (int k = 0; k < 3; k++) tick(1'b1, 4'b0001, slot(0, DW'(8'hE0 + k)), 2'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, '0, '0, 2'd0, 1'b1);
         e = scoreQ.pop_front();
         total++;
         if (validOut !== 1'b1 || dataOut !== e) begin bad++; $display("[TB] FAIL prewrap_pop got=%b/%h want=1/%h", validOut, dataOut, e); end
      end
      for (int k = 0; k < DEPTH; k++) tick(1'b1, 4'b0001, slot(0, DW'(8'hC0 + k)), 2'd0, 1'b0);
      total++;
      if (bufFull !== modelFull() || bufFull[0] !== 1'b1) begin bad++; $display("[TB] FAIL fill_full got=%b want=%b", bufFull, modelFull()); end
      tick(1'b1, 4'b0001, slot(0, 8'hFF), 2'd0, 1'b0);
      total++;
      if (bufFull[0] !== 1'b1) begin bad++; $display("[TB] FAIL overflow_full got=%b want=1", bufFull[0]); end
`ifdef QUEUE_BANK_ERR_EN
      total++;
      if (errOv !== expOv) begin bad++; $display("[TB] FAIL overflow_err got=%b want=%b", errOv, expOv); end
`endif
      // Back-to-back pops drain the full queue in order.
      for (int k = 0; k < DEPTH; k++) begin
         tick(1'b1, '0, '0, 2'd0, 1'b1);
         e = scoreQ.pop_front();
         total++;
         if (validOut !== 1'b1 || dataOut !== e) begin bad++; $display("[TB] FAIL wrap_pop got=%b/%h want=1/%h", validOut, dataOut, e); end
      end
      idle();
      total++;
      if (bufEmpty !== modelEmpty()) begin bad++; $display("[TB] FAIL wrap_empty got=%b want=%b", bufEmpty, modelEmpty()); end
   endtask

   task automatic test_full_push_pop();
      logic [DW-1:0] e;
      for (int k = 0; k < DEPTH; k++) tick(1'b1, 4'b0010, slot(1, DW'(8'h10 + k)), 2'd0, 1'b0);
      tick(1'b1, 4'b0010, slot(1, 8'h55), 2'd1, 1'b1);
      e = scoreQ.pop_front();
      total++;
      if (validOut !== 1'b1 || dataOut !== e) begin bad++; $display("[TB] FAIL fullpp_pop got=%b/%h want=1/%h", validOut, dataOut, e); end
      total++;
      if (bufFull[1] !== 1'b1 || bufFull !== modelFull()) begin bad++; $display("[TB] FAIL fullpp_full got=%b want=%b", bufFull, modelFull()); end
      for (int k = 0; k < DEPTH; k++) begin
         tick(1'b1, '0, '0, 2'd1, 1'b1);
         e = scoreQ.pop_front();
         total++;
         if (validOut !== 1'b1 || dataOut !== e) begin bad++; $display("[TB] FAIL fullpp_drain got=%b/%h want=1/%h", validOut, dataOut, e); end
      end
      total++;
      if (dataOut !== 8'h55) begin bad++; $display("[TB] FAIL fullpp_last got=%h want=55", dataOut); end
      total++;
      if (bufEmpty !== modelEmpty()) begin bad++; $display("[TB] FAIL fullpp_empty got=%b want=%b", bufEmpty, modelEmpty()); end
   endtask

   task automatic test_pop_empty();
      tick(1'b1, '0, '0, 2'd3, 1'b1);
      total++;
      if (validOut !== 1'b0) begin bad++; $display("[TB] FAIL popempty_valid got=%b want=0", validOut); end
      total++;
      if (dataOut !== expData) begin bad++; $display("[TB] FAIL popempty_hold got=%h want=%h", dataOut, expData); end
`ifdef QUEUE_BANK_ERR_EN
      total++;
      if (errUn !== expUn) begin bad++; $display("[TB] FAIL underflow_err got=%b want=%b", errUn, expUn); end
`endif
   endtask

   task automatic test_enable_hold();
      logic [DW-1:0] e;
      tick(1'b1, 4'b0001, slot(0, 8'h31), 2'd0, 1'b0);
      tick(1'b0, 4'b1111, {8'h44, 8'h43, 8'h42, 8'h41}, 2'd0, 1'b1);
      total++;
      if (validOut !== 1'b0 || dataOut !== expData) begin bad++; $display("[TB] FAIL enb_hold_out got=%b/%h want=0/%h", validOut, dataOut, expData); end
      total++;
      if (bufEmpty !== modelEmpty() || bufFull !== modelFull()) begin bad++; $display("[TB] FAIL enb_hold_flags got=%b/%b want=%b/%b", bufEmpty, bufFull, modelEmpty(), modelFull()); end
      tick(1'b1, '0, '0, 2'd0, 1'b1);
      e = scoreQ.pop_front();
      total++;
      if (validOut !== 1'b1 || dataOut !== e) begin bad++; $display("[TB] FAIL enb_resume got=%b/%h want=1/%h", validOut, dataOut, e); end
`ifdef QUEUE_BANK_ERR_EN
      total++;
      if (errOv !== expOv || errUn !== expUn) begin bad++; $display("[TB] FAIL enb_err got=%b/%b want=%b/%b", errOv, errUn, expOv, expUn); end
`endif
   endtask

   task automatic test_mid_reset();
      tick(1'b1, 4'b1111, {8'h04, 8'h03, 8'h02, 8'h01}, 2'd0, 1'b0);
      tick(1'b1, 4'b0101, {8'h00, 8'h07, 8'h00, 8'h05}, 2'd0, 1'b1);
      total++;
      if (bufEmpty !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_pre got=%b want=0000", bufEmpty); end
      #2;
      rstN = 1'b0;
      #1;
      clearModel();
      total++;
      if (bufEmpty !== 4'b1111 || bufFull !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_flags got=%b/%b want=1111/0000", bufEmpty, bufFull); end
      total++;
      if (validOut !== 1'b0 || dataOut !== 8'h00) begin bad++; $display("[TB] FAIL midrst_out got=%b/%h want=0/00", validOut, dataOut); end
      @(negedge clk);
      rstN = 1'b1;
      push = '0; selEnb = 1'b0;
      tick(1'b1, '0, '0, 2'd2, 1'b1);
      total++;
      if (validOut !== 1'b0 || bufEmpty !== 4'b1111) begin bad++; $display("[TB] FAIL midrst_after got=%b/%b want=0/1111", validOut, bufEmpty); end
   endtask

   initial begin
      test_reset();
      test_basic_pop();
      test_fill_wrap();
      test_full_push_pop();
      test_pop_empty();
      test_enable_hold();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
